// File: rtl/io_mem_responder.sv
// io_mem_responder
//   Target for the IO request/ack bus. It accepts one read or write at a time
//   into a byte-addressable local memory. The request acknowledge can be held
//   off for ACK_WAIT cycles. Completion is a single io_data_ack pulse that
//   arrives LATENCY posedges after the accept edge, with the accept edge
//   counted as the first of them.
//
// Ports
//   clk         : clock, all state on posedge
//   rst         : asynchronous reset, active high (clears memory too)
//   io_req      : request valid
//   io_wr       : 1 = write, 0 = read (qualified by io_req)
//   io_wen[3:0] : write byte enables, bit i -> lane i
//   io_addr     : byte address; [31:28] must equal BASE_NIBBLE to hit
//   io_wdata    : write data, lane i = bits [8i+7:8i]
//   io_req_ack  : request accepted this cycle (combinational)
//   io_rdata    : read data, non-zero only during io_data_ack of a read hit
//   io_data_ack : one-cycle completion pulse
//   io_err      : address-decode miss, valid with io_data_ack
module io_mem_responder #(
  parameter int          DEPTH       = 256,
  parameter int          LATENCY     = 1,
  parameter int          ACK_WAIT    = 0,
  parameter logic [3:0]  BASE_NIBBLE = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_req,
  input  logic        io_wr,
  input  logic [3:0]  io_wen,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_wdata,
  output logic        io_req_ack,
  output logic [31:0] io_rdata,
  output logic        io_data_ack,
  output logic        io_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_nxt;
  logic [3:0]  lat_cnt, lat_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] lane_idx [4];
  logic          accept;
  logic          hit;
  logic [31:0]   rdata_p1;
  logic          hit_p1;

  // rst gates the acknowledge so nothing is accepted while reset is held,
  // even when ACK_WAIT=0 and the counters already sit at their reset value.
  assign io_req_ack = io_req && !rst && ((state == IDLE) || (state == WAIT))
                      && (wait_cnt == 4'(ACK_WAIT));
  assign accept     = io_req && io_req_ack;
  assign hit        = (io_addr[31:28] == BASE_NIBBLE);

  // Lanes of a misaligned access wrap modulo DEPTH through the AW-bit add.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_idx[i] = io_addr[AW-1:0] + AW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      lat_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      lat_cnt  <= lat_nxt;
    end
  end

  // lat_cnt counts posedges including the accept edge, so RESP is entered on
  // the edge where the count would reach LATENCY.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    lat_nxt   = lat_cnt;
    case (state)
      IDLE, WAIT: begin
        if (accept) begin
          wait_nxt  = '0;
          lat_nxt   = 4'd1;
          state_nxt = (LATENCY == 1) ? RESP : BUSY;
        end else if (io_req) begin
          wait_nxt  = wait_cnt + 4'd1;
          state_nxt = WAIT;
        end else begin
          wait_nxt  = '0;
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if ((lat_cnt + 4'd1) == 4'(LATENCY)) begin
          lat_nxt   = '0;
          state_nxt = RESP;
        end else begin
          lat_nxt   = lat_cnt + 4'd1;
        end
      end
      RESP: begin
        lat_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        wait_nxt  = '0;
        lat_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Accept edge -> p1: memory update and read capture. Writes and misses
  // capture zero so the response mux only needs the RESP state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        mem[AW'(j)] <= '0;
      end
      rdata_p1 <= '0;
      hit_p1   <= 1'b0;
    end else if (accept) begin
      hit_p1 <= hit;
      if (io_wr) begin
        rdata_p1 <= '0;
        if (hit) begin
          for (int i = 0; i < 4; i++) begin
            if (io_wen[i]) begin
              mem[lane_idx[i]] <= io_wdata[8*i +: 8];
            end
          end
        end
      end else begin
        rdata_p1 <= hit ? {mem[lane_idx[3]], mem[lane_idx[2]],
                           mem[lane_idx[1]], mem[lane_idx[0]]} : 32'h0;
      end
    end
  end

  // p1 -> response outputs, driven only in RESP.
  assign io_data_ack = (state == RESP);
  assign io_rdata    = (state == RESP) ? rdata_p1 : 32'h0;
  assign io_err      = (state == RESP) && !hit_p1;

endmodule

// File: tb/tb_io_mem_responder.sv
// Scoreboard bench for io_mem_responder. Two instances: u0 (ACK_WAIT=0,
// LATENCY=1) and u1 (ACK_WAIT=3, LATENCY=4). Drivers push the hand-computed
// response when a request is acknowledged; a monitor pops and compares it on
// every io_data_ack, including the accept-to-ack latency.
module tb_io_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst     [2];
  logic        req     [2];
  logic        wr      [2];
  logic [3:0]  wen     [2];
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic        req_ack [2];
  logic [31:0] rdata   [2];
  logic        data_ack[2];
  logic        err     [2];

  io_mem_responder #(.DEPTH(256), .LATENCY(1), .ACK_WAIT(0), .BASE_NIBBLE(4'hF)) u0 (
    .clk(clk), .rst(rst[0]), .io_req(req[0]), .io_wr(wr[0]), .io_wen(wen[0]),
    .io_addr(addr[0]), .io_wdata(wdata[0]), .io_req_ack(req_ack[0]),
    .io_rdata(rdata[0]), .io_data_ack(data_ack[0]), .io_err(err[0]));

  io_mem_responder #(.DEPTH(256), .LATENCY(4), .ACK_WAIT(3), .BASE_NIBBLE(4'hF)) u1 (
    .clk(clk), .rst(rst[1]), .io_req(req[1]), .io_wr(wr[1]), .io_wen(wen[1]),
    .io_addr(addr[1]), .io_wdata(wdata[1]), .io_req_ack(req_ack[1]),
    .io_rdata(rdata[1]), .io_data_ack(data_ack[1]), .io_err(err[1]));

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qpop(input int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic qpush(input int d, input logic [31:0] r, input logic e, input string nm);
    exp_t x;
    x.rdata = r; x.err = e; x.acc = cyc; x.name = nm;
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  // Monitor: compare every completion against the scoreboard; outside a
  // completion the response outputs must stay at zero.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (data_ack[d] === 1'b1) begin
        exp_t e;
        if (qsize(d) == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_ack u%0d: io_data_ack=1 got, none expected", d);
        end else begin
          e = qpop(d);
          check({e.name, " rdata"}, rdata[d], e.rdata);
          check({e.name, " err"}, 32'(err[d]), 32'(e.err));
          check({e.name, " latency"}, 32'(cyc - e.acc), (d == 0) ? 32'd1 : 32'd4);
        end
      end else if (rst[d] === 1'b0) begin
        check($sformatf("idle_outputs u%0d", d), {rdata[d][30:0], err[d]}, 32'h0);
      end
    end
  end

  task automatic drain(input int d, input string nm);
    int k = 0;
    while (qsize(d) != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (qsize(d) != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s completion: got none after %0d cycles, expected io_data_ack", nm, k);
      if (d == 0) q0.delete();
      else        q1.delete();
    end
  endtask

  // Issue one transaction, check how many cycles io_req was held before
  // io_req_ack, push the expected response and wait for its completion.
  task automatic txn(input int d, input bit w, input logic [3:0] be, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] er, input bit ee,
                     input int exp_wait, input string nm);
    int  n   = 0;
    bit  got = 0;
    @(posedge clk); #1;
    req[d] = 1'b1; wr[d] = w; wen[d] = be; addr[d] = a; wdata[d] = wd;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (req_ack[d] === 1'b1) got = 1;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s ack: got no io_req_ack in %0d cycles, expected after %0d", nm, n, exp_wait);
      @(posedge clk); #1;
      req[d] = 1'b0;
      return;
    end
    check({nm, " ack_wait"}, 32'(n), 32'(exp_wait));
    qpush(d, er, ee, nm);
    @(posedge clk); #1;
    req[d] = 1'b0;
    drain(d, nm);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req[d] = 1'b0; wr[d] = 1'b0; wen[d] = 4'h0;
      addr[d] = 32'h0; wdata[d] = 32'h0;
    end
    req[0] = 1'b1;
    addr[0] = 32'hF000_0010;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset req_ack u%0d", d), 32'(req_ack[d]), 32'h0);
      check($sformatf("reset data_ack u%0d", d), 32'(data_ack[d]), 32'h0);
      check($sformatf("reset rdata u%0d", d), rdata[d], 32'h0);
      check($sformatf("reset err u%0d", d), 32'(err[d]), 32'h0);
    end
    @(posedge clk); #1;
    req[0] = 1'b0; rst[0] = 1'b0; rst[1] = 1'b0;

    // u0: ACK_WAIT=0, LATENCY=1
    txn(0, 1, 4'b1111, 32'hF000_0010, 32'hDEAD_BEEF, 32'h0,         0, 1, "wr_full");
    txn(0, 0, 4'b0000, 32'hF000_0010, 32'h0,         32'hDEAD_BEEF, 0, 1, "rd_full");
    txn(0, 1, 4'b0101, 32'hF000_0020, 32'h1122_3344, 32'h0,         0, 1, "wr_be");
    txn(0, 0, 4'b0000, 32'hF000_0020, 32'h0,         32'h0022_0044, 0, 1, "rd_be");
    txn(0, 1, 4'b1111, 32'hF000_00FE, 32'hAABB_CCDD, 32'h0,         0, 1, "wr_wrap");
    txn(0, 0, 4'b0000, 32'hF000_0000, 32'h0,         32'h0000_AABB, 0, 1, "rd_wrap_lo");
    txn(0, 0, 4'b0000, 32'hF000_00FE, 32'h0,         32'hAABB_CCDD, 0, 1, "rd_wrap_fe");
    txn(0, 1, 4'b1111, 32'hE000_0010, 32'h1234_5678, 32'h0,         1, 1, "wr_miss");
    txn(0, 0, 4'b0000, 32'hF000_0010, 32'h0,         32'hDEAD_BEEF, 0, 1, "rd_after_miss");
    txn(0, 0, 4'b0000, 32'hE000_0010, 32'h0,         32'h0,         1, 1, "rd_miss");
    txn(0, 0, 4'b0000, 32'hF000_0011, 32'h0,         32'h00DE_ADBE, 0, 1, "rd_misaligned");
    txn(0, 1, 4'b0000, 32'hF000_0010, 32'hFFFF_FFFF, 32'h0,         0, 1, "wr_wen0");
    txn(0, 0, 4'b0000, 32'hF000_0010, 32'h0,         32'hDEAD_BEEF, 0, 1, "rd_after_wen0");

    // u1: ACK_WAIT=3, LATENCY=4
    txn(1, 1, 4'b1111, 32'hF000_0010, 32'hCAFE_F00D, 32'h0,         0, 4, "u1_wr");
    txn(1, 0, 4'b0000, 32'hF000_0010, 32'h0,         32'hCAFE_F00D, 0, 4, "u1_rd");

    // Request held straight through BUSY/RESP: the second ack comes only
    // after 3 BUSY cycles, 1 RESP cycle and 4 IDLE/WAIT cycles.
    @(posedge clk); #1;
    req[1] = 1'b1; wr[1] = 1'b0; wen[1] = 4'h0; addr[1] = 32'hF000_0010;
    n = 0; got = 0;
    while (!got && n < 40) begin @(negedge clk); n++; if (req_ack[1] === 1'b1) got = 1; end
    check("held first ack_wait", 32'(n), 32'd4);
    if (got) qpush(1, 32'hCAFE_F00D, 1'b0, "held_first");
    n = 0; got = 0;
    while (!got && n < 40) begin @(negedge clk); n++; if (req_ack[1] === 1'b1) got = 1; end
    check("held second ack_wait", 32'(n), 32'd8);
    if (got) qpush(1, 32'hCAFE_F00D, 1'b0, "held_second");
    @(posedge clk); #1;
    req[1] = 1'b0;
    drain(1, "held");

    // Withdraw while wait_cnt=2: no ack and no write.
    @(posedge clk); #1;
    req[1] = 1'b1; wr[1] = 1'b1; wen[1] = 4'hF; addr[1] = 32'hF000_0030; wdata[1] = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge clk);
      check("withdraw req_ack", 32'(req_ack[1]), 32'h0);
    end
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(negedge clk);
    check("withdraw after req_ack", 32'(req_ack[1]), 32'h0);
    txn(1, 0, 4'b0000, 32'hF000_0030, 32'h0, 32'h0, 0, 4, "rd_after_withdraw");

    // Reset during BUSY: transaction abandoned, memory cleared.
    @(posedge clk); #1;
    req[1] = 1'b1; wr[1] = 1'b1; wen[1] = 4'hF; addr[1] = 32'hF000_0050; wdata[1] = 32'h1234_5678;
    n = 0; got = 0;
    while (!got && n < 40) begin @(negedge clk); n++; if (req_ack[1] === 1'b1) got = 1; end
    check("busy_rst ack_wait", 32'(n), 32'd4);
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    rst[1] = 1'b1;
    req[1] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("busy_rst req_ack", 32'(req_ack[1]), 32'h0);
      check("busy_rst data_ack", 32'(data_ack[1]), 32'h0);
      check("busy_rst rdata", rdata[1], 32'h0);
      check("busy_rst err", 32'(err[1]), 32'h0);
    end
    @(posedge clk); #1;
    rst[1] = 1'b0;
    req[1] = 1'b0;
    repeat (6) @(negedge clk);
    txn(1, 0, 4'b0000, 32'hF000_0010, 32'h0, 32'h0, 0, 4, "rd_cleared_10");
    txn(1, 0, 4'b0000, 32'hF000_0050, 32'h0, 32'h0, 0, 4, "rd_cleared_50");

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/io_mem_responder.md
Name: io_mem_responder

Overview:
- Synthesizable responder (target) for the IO request/ack bus driven by the spike bench initiator.
- Accepts one read or write at a time and stores it in a byte-addressable local memory.
- Returns read data with a configurable acknowledge delay and a configurable response latency.
- Replaces the trivial behavioural memory and is used to stress initiator handshake timing.

Parameters:
DEPTH, 256, memory size in bytes; power of 2, >=4; index width AW=log2(DEPTH)
LATENCY, 1, posedges from accept edge to io_data_ack high; legal 1..15
ACK_WAIT, 0, cycles io_req must be held before io_req_ack; legal 0..15
BASE_NIBBLE, 4'hF, required value of io_addr[31:28]

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  asynchronous reset, active high
io_req  input  1  request valid
io_wr  input  1  1=write, 0=read; qualified by io_req
io_wen  input  4  write byte enables, bit i -> byte lane i
io_addr  input  32  byte address
io_wdata  input  32  write data, lane i = bits [8i+7:8i]
io_req_ack  output  1  request accepted (combinational)
io_rdata  output  32  read data, valid only while io_data_ack=1
io_data_ack  output  1  one-cycle completion pulse (reads and writes)
io_err  output  1  address-decode error; valid only with io_data_ack

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, all counters=0, memory cleared to 0.
  - io_data_ack=0, io_rdata=0, io_err=0; io_req_ack=0 while rst=1.
- States:
  - IDLE: wait_cnt=0.
  - WAIT: io_req held, counting wait_cnt.
  - BUSY: transaction accepted, counting lat_cnt.
  - RESP: io_data_ack cycle.
- io_req_ack = io_req & (state is IDLE or WAIT) & (wait_cnt==ACK_WAIT). Never high in BUSY or RESP.
  - ACK_WAIT=0: ack in the same cycle as io_req from IDLE.
- Transitions:
  - IDLE: io_req & !ack -> WAIT (wait_cnt=1).
  - WAIT: io_req & !ack -> wait_cnt+1; io_req=0 -> IDLE, wait_cnt=0 (withdrawn request, no side effects).
  - Accept edge (io_req & io_req_ack at posedge) -> BUSY, lat_cnt=1; if LATENCY==1, go directly to RESP.
  - BUSY: lat_cnt+1 each cycle; lat_cnt==LATENCY -> RESP.
  - RESP -> IDLE. No request is accepted in RESP.
- Decode: hit = (io_addr[31:28]==BASE_NIBBLE), sampled at the accept edge.
- Byte index for lane i = (io_addr[AW-1:0]+i) mod DEPTH; wraps at the top of memory.
- Write, on the accept edge: if hit, lane i with io_wen[i]=1 is written to its byte index.
  - io_wen=0 is legal: no bytes change, transaction still completes.
- Read, on the accept edge: all 4 lanes are captured from memory.
  - A read accepted after a write sees the written data.
- Misaligned addresses are legal, served byte-wise with wrap.
- RESP cycle outputs:
  - io_data_ack=1.
  - Read hit: io_rdata = captured word.
  - Write, or any miss: io_rdata=0.
  - io_err = !hit.
- Outside RESP: io_data_ack=0, io_rdata=0, io_err=0.
- Timing: data_ack rises LATENCY posedges after the accept edge. Minimum spacing between accepts = LATENCY+1 cycles.
- Miss: the write is suppressed; the completion is still produced.
- Reset mid-transaction: the transaction is abandoned, no io_data_ack, memory cleared.
- io_wr/io_wen/io_addr/io_wdata are sampled only at the accept edge; X outside that edge is ignored.

Test Plan:
- ACK_WAIT=0, LATENCY=1:
  - write 0xF0000010, wen=4'b1111, data 0xDEADBEEF -> io_req_ack same cycle, io_data_ack 1 cycle later, io_err=0.
  - then read 0xF0000010 -> io_rdata=0xDEADBEEF.
- Byte enables: write 0xF0000020 data 0x11223344 wen=4'b0101, after reset -> read returns 0x00220044.
- Wrap, DEPTH=256: write 0xF00000FE wen=4'b1111 data 0xAABBCCDD -> bytes FE=DD, FF=CC, 00=BB, 01=AA; read 0xF0000000 returns 0x0000AABB.
- ACK_WAIT=3, LATENCY=4:
  - req held -> io_req_ack in the 4th cycle of io_req.
  - io_data_ack exactly 4 posedges after accept.
  - second req held through BUSY/RESP is not acked until back in IDLE/WAIT.
- Miss: write 0xE0000010 data 0x12345678 -> io_data_ack=1 with io_err=1; subsequent read 0xF0000010 returns unchanged contents.
- Robustness:
  - withdraw io_req at wait_cnt=2 (ACK_WAIT=3) -> no ack, memory unchanged.
  - assert rst in BUSY -> no io_data_ack, outputs 0, memory reads back 0.
